// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// Includes the UART register map it is normally pointed at.
package axi_lite_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_READ  = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [15:0] REG_TXRX    = 16'h0;
  localparam logic [15:0] REG_STATUS  = 16'h4;
  localparam logic [15:0] REG_DIVISOR = 16'h8;
  localparam logic [15:0] REG_FRAME   = 16'hC;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
// Channel names follow AXI, without the m_axi_ prefix.
interface axi_lite_master_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_lite_watchdog.sv
// Saturating stall counter; expired is sticky until the next clear.
// Expired rises on the same edge the count reaches the limit.
module axi_lite_watchdog #(
  parameter int P_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(P_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(P_TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (run && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LIMIT - 1'b1)
        expired <= 1'b1;
    end
  end
endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one response out.
// Every output is a flop loaded from the next-state logic.
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int P_M_AXI_DATA_WIDTH = 32,
  parameter int P_M_AXI_ADDR_WIDTH = 16,
  parameter int P_TIMEOUT          = 1024
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_write,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [P_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [P_M_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [P_M_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                      o_rsp_resp,
  output logic                            o_rsp_timeout,
  axi_lite_master_if.master               m_axi
);
  localparam int AW = P_M_AXI_ADDR_WIDTH;
  localparam int DW = P_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  state_t state_q, state_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic arvalid_q, arvalid_d;
  logic bready_q, bready_d;
  logic rready_q, rready_d;
  logic cmd_ready_q, cmd_ready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    resp_q, resp_d;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
  logic busy;

  assign accept = cmd_ready_q & i_cmd_valid;
  assign aw_hs  = awvalid_q & m_axi.awready;
  assign w_hs   = wvalid_q & m_axi.wready;
  assign b_hs   = bready_q & m_axi.bvalid;
  assign ar_hs  = arvalid_q & m_axi.arready;
  assign r_hs   = rready_q & m_axi.rvalid;
  assign rsp_hs = rsp_valid_q & i_rsp_ready;
  assign busy   = state_q inside {S_WRITE, S_WRESP, S_READ, S_RDATA};

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        cmd_ready_d = 1'b0;
        if (i_cmd_write) begin
          state_d   = S_WRITE;
          awaddr_d  = i_cmd_addr;
          wdata_d   = i_cmd_wdata;
          wstrb_d   = i_cmd_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          state_d   = S_READ;
          araddr_d  = i_cmd_addr;
          arvalid_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: if (b_hs) begin
        state_d     = S_RSP;
        bready_d    = 1'b0;
        rdata_d     = '0;
        resp_d      = m_axi.bresp;
        rsp_valid_d = 1'b1;
      end
      S_READ: if (ar_hs) begin
        state_d   = S_RDATA;
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      S_RDATA: if (r_hs) begin
        state_d     = S_RSP;
        rready_d    = 1'b0;
        rdata_d     = m_axi.rdata;
        resp_d      = m_axi.rresp;
        rsp_valid_d = 1'b1;
      end
      S_RSP: if (rsp_hs) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q     <= S_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  axi_lite_watchdog #(
    .P_TIMEOUT(P_TIMEOUT)
  ) u_watchdog (
    .clk    (m_axi_aclk),
    .rst_n  (m_axi_aresetn),
    .clear  (accept),
    .run    (busy),
    .expired(o_rsp_timeout)
  );

  assign o_cmd_ready   = cmd_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rdata_q;
  assign o_rsp_resp    = resp_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
endmodule
